keypad_scanner: RTL

//  Front end of the calculator: scans a 4x4 matrix keypad, debounces it, and decodes each press.

---
 rtl/keypad_pkg.sv | 57 +++++
 rtl/keypad_sync.sv | 25 ++
 rtl/keypad_scanner.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// keypad_pkg: shared state, operator and key-class definitions plus the keypad map.
// Latency: n/a (types and a pure function). Backpressure: n/a.
// Key index is {row[1:0], col[1:0]}.
package keypad_pkg;

    typedef enum logic [2:0] {
        ST_SCAN     = 3'd0,
        ST_DEBOUNCE = 3'd1,
        ST_LOAD     = 3'd2,
        ST_STROBE   = 3'd3,
        ST_RELEASE  = 3'd4
    } scan_state_t;

    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_MUL = 3'b100;

    typedef enum logic [2:0] {
        KC_DIGIT = 3'd0,
        KC_OP    = 3'd1,
        KC_EQ    = 3'd2,
        KC_CLR   = 3'd3,
        KC_NONE  = 3'd4
    } key_class_t;

    typedef struct packed {
        key_class_t cls;
        logic [3:0] val;
    } key_info_t;

    // Operators carry their one-hot code in val[2:0].
    function automatic key_info_t keymap(input logic [3:0] idx);
        key_info_t ki;
        ki.cls = KC_NONE;
        ki.val = 4'd0;
        case (idx)
            4'd0:  begin ki.cls = KC_DIGIT; ki.val = 4'd1; end
            4'd1:  begin ki.cls = KC_DIGIT; ki.val = 4'd2; end
            4'd2:  begin ki.cls = KC_DIGIT; ki.val = 4'd3; end
            4'd3:  begin ki.cls = KC_OP;    ki.val = {1'b0, OP_ADD}; end
            4'd4:  begin ki.cls = KC_DIGIT; ki.val = 4'd4; end
            4'd5:  begin ki.cls = KC_DIGIT; ki.val = 4'd5; end
            4'd6:  begin ki.cls = KC_DIGIT; ki.val = 4'd6; end
            4'd7:  begin ki.cls = KC_OP;    ki.val = {1'b0, OP_SUB}; end
            4'd8:  begin ki.cls = KC_DIGIT; ki.val = 4'd7; end
            4'd9:  begin ki.cls = KC_DIGIT; ki.val = 4'd8; end
            4'd10: begin ki.cls = KC_DIGIT; ki.val = 4'd9; end
            4'd11: begin ki.cls = KC_OP;    ki.val = {1'b0, OP_MUL}; end
            4'd13: begin ki.cls = KC_DIGIT; ki.val = 4'd0; end
            4'd14: ki.cls = KC_EQ;
            4'd15: ki.cls = KC_CLR;
            default: ki.cls = KC_NONE;
        endcase
        return ki;
    endfunction

endpackage

// File: rtl/keypad_sync.sv
// keypad_sync: 2-flop synchronizer for the asynchronous keypad row inputs.
// Latency: 2 clk cycles. Backpressure: none.
// Reset clears both stages so no stale key survives RST.
module keypad_sync #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             RST,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (RST) begin
            meta <= '0;
            dout <= '0;
        end else begin
            meta <= din;
            dout <= meta;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans/debounces a 4x4 keypad and decodes presses into gencon's digit, operator, equal and clear inputs.
// Latency: 2-cycle sync + DEBOUNCE_CNT stable cycles to LOAD; read_input follows keypad_input by one cycle.
// Backpressure: none; equal_input holds until complete. KEYPAD_AUTOREPEAT_EN enables digit auto-repeat.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 20000,
    parameter int REPEAT_DELAY = 500000,
    parameter int REPEAT_RATE  = 100000
) (
    input  logic       clk,
    input  logic       RST,
    input  logic [3:0] row_sense,
    output logic [3:0] col_drive,
    input  logic       complete,
    output logic [3:0] keypad_input,
    output logic       read_input,
    output logic [2:0] operator_input,
    output logic       equal_input,
    output logic       clear_output
);

    // Rows lag the column drive by the 2-cycle synchronizer, so a column is
    // only sampled from its third cycle on; the dwell is stretched to fit one sample.
    localparam int DWELL = (SCAN_DIV < 3) ? 3 : SCAN_DIV;
    localparam int M1    = (DWELL > DEBOUNCE_CNT) ? DWELL : DEBOUNCE_CNT;
    localparam int M2    = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int MAXP  = (M1 > M2) ? M1 : M2;
    localparam int CW    = $clog2(MAXP + 1);

    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
    localparam logic [CW-1:0] DEB_LAST   = CW'(DEBOUNCE_CNT - 1);
    localparam logic [CW-1:0] SETTLED    = CW'(2);

    logic [3:0]  row_sync;
    scan_state_t state;
    logic [CW-1:0] div_cnt;
    logic [CW-1:0] cnt;
    logic [3:0]  key_idx;
    logic [3:0]  key_rows;
    logic        strobe_en;
    logic [1:0]  row_enc;
    logic [1:0]  col_enc;
    logic        row_one;
    key_info_t   ki;

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam logic [CW-1:0] REP_D_LAST = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] REP_R_LAST = CW'(REPEAT_RATE - 1);
    logic [CW-1:0] rep_cnt;
    logic          rep_first;
`endif

    keypad_sync #(.WIDTH(4)) u_sync (
        .clk  (clk),
        .RST  (RST),
        .din  (row_sense),
        .dout (row_sync)
    );

    assign row_one = (row_sync != 4'd0) && ((row_sync & (row_sync - 4'd1)) == 4'd0);
    assign ki      = keymap(key_idx);

    always_comb begin
        row_enc = 2'd0;
        col_enc = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (row_sync[i])  row_enc = 2'(i);
            if (col_drive[i]) col_enc = 2'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            state          <= ST_SCAN;
            col_drive      <= 4'b0001;
            div_cnt        <= '0;
            cnt            <= '0;
            key_idx        <= 4'd0;
            key_rows       <= 4'd0;
            strobe_en      <= 1'b0;
            keypad_input   <= 4'd0;
            read_input     <= 1'b0;
            operator_input <= 3'b000;
            equal_input    <= 1'b0;
            clear_output   <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_cnt        <= '0;
            rep_first      <= 1'b1;
`endif
        end else begin
            read_input   <= 1'b0;
            clear_output <= 1'b0;
            if (equal_input && complete) equal_input <= 1'b0;

            case (state)
                ST_SCAN: begin
                    if (div_cnt >= SETTLED && row_one) begin
                        key_idx  <= {row_enc, col_enc};
                        key_rows <= row_sync;
                        cnt      <= '0;
                        state    <= ST_DEBOUNCE;
                    end else if (div_cnt == DWELL_LAST) begin
                        col_drive <= {col_drive[2:0], col_drive[3]};
                        div_cnt   <= '0;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                ST_DEBOUNCE: begin
                    if (row_sync != key_rows) begin
                        col_drive <= {col_drive[2:0], col_drive[3]};
                        div_cnt   <= '0;
                        state     <= ST_SCAN;
                    end else if (cnt == DEB_LAST) begin
                        state <= ST_LOAD;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_LOAD: begin
                    state     <= ST_STROBE;
                    strobe_en <= 1'b0;
                    // A pending equal request swallows everything except clear.
                    case (ki.cls)
                        KC_DIGIT: if (!equal_input) begin
                            keypad_input <= ki.val;
                            strobe_en    <= 1'b1;
                        end
                        KC_OP: if (!equal_input) operator_input <= ki.val[2:0];
                        KC_EQ: if (!equal_input) equal_input <= 1'b1;
                        KC_CLR: begin
                            clear_output   <= 1'b1;
                            operator_input <= 3'b000;
                            equal_input    <= 1'b0;
                            keypad_input   <= 4'd0;
                        end
                        default: ;
                    endcase
                end
                ST_STROBE: begin
                    read_input <= strobe_en;
                    cnt        <= '0;
                    state      <= ST_RELEASE;
`ifdef KEYPAD_AUTOREPEAT_EN
                    rep_cnt    <= '0;
                    rep_first  <= 1'b1;
`endif
                end
                ST_RELEASE: begin
                    if (row_sync != 4'd0) begin
                        cnt <= '0;
                    end else if (cnt == DEB_LAST) begin
                        div_cnt <= '0;
                        state   <= ST_SCAN;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
`ifdef KEYPAD_AUTOREPEAT_EN
                    if (strobe_en && row_sync == key_rows) begin
                        if (rep_cnt == (rep_first ? REP_D_LAST : REP_R_LAST)) begin
                            read_input <= 1'b1;
                            rep_cnt    <= '0;
                            rep_first  <= 1'b0;
                        end else if (rep_cnt != '1) begin
                            rep_cnt <= rep_cnt + 1'b1;
                        end
                    end
`endif
                end
                default: state <= ST_SCAN;
            endcase
        end
    end

endmodule
